pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges four sources into per-stage stall and flush controls: the hazard unit's load-use/branch stall in D, a multi-cycle mult/div op held in E, a data-memory wait in M, and a taken-branch redirect in D. It owns the mult/div cycle counter, the memory-wait timeout, and a stall-cycle performance counter. It replaces the direct stallF/stallD/flush wiring from the hazard unit.

Parameters:
MDU_CYCLES, 32, cycles a mult/div occupies E (>=1)
CNT_W, 6, width of MDU counter (must hold MDU_CYCLES-1)
MEM_TIMEOUT, 255, consecutive M-wait cycles before mem_timeout is raised (>=1)
PERF_W, 32, width of stall performance counter

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
hazard_stallD  input  1  load-use/branch stall request from hazard detection
branch_takenD  input  1  branch/jump resolved taken in D
mdu_startE  input  1  mult/div instruction currently in E
dmem_reqM  input  1  load/store in M requesting memory
dmem_ackM  input  1  memory completes access this cycle
stallF  output  1  hold PC
stallD  output  1  hold IF/ID
stallE  output  1  hold ID/EX
stallM  output  1  hold EX/MEM
flushD  output  1  clear IF/ID (redirect)
flushE  output  1  bubble into ID/EX
flushM  output  1  bubble into EX/MEM
flushW  output  1  bubble into MEM/WB
mdu_busy  output  1  MDU counter active
mdu_doneE  output  1  mult/div result valid this cycle
mem_timeout  output  1  sticky: memory wait exceeded MEM_TIMEOUT
stall_cycles  output  PERF_W  count of cycles with stallF=1, saturating

Behaviour:
- Registers: mdu_active, mdu_cnt[CNT_W], wait_cnt, mem_timeout, stall_cycles; all 0 on rst. Stall/flush outputs are combinational; with rst held and inputs 0, every output is 0.
- mem_stall = dmem_reqM & ~dmem_ackM.
- mdu_done = mdu_active & (mdu_cnt==0); mdu_doneE = mdu_done.
- mdu_stall = mdu_startE & ~mdu_done.
- stallM = mem_stall; stallE = mem_stall | mdu_stall; stallD = stallE | hazard_stallD; stallF = stallD.
- flushD = branch_takenD & ~stallD (a redirect under stall is deferred; D re-resolves the branch).
- flushE = stallD & ~stallE; flushM = stallE & ~stallM; flushW = stallM.
- MDU sequencing: if ~mdu_active & mdu_startE, load mdu_cnt=MDU_CYCLES-1 and set mdu_active. While active with cnt!=0, decrement every cycle, including during mem_stall. At cnt==0 with ~mem_stall, clear mdu_active (instruction leaves E at that edge). At cnt==0 with mem_stall, hold active/done until the stall drops. Start-to-done latency is MDU_CYCLES stalled cycles, with done on cycle MDU_CYCLES+1. MDU_CYCLES=1 gives one stall cycle. mdu_busy = mdu_active.
- Memory wait: wait_cnt increments while mem_stall and saturates at MEM_TIMEOUT. It clears on any cycle without mem_stall. When wait_cnt reaches MEM_TIMEOUT, set mem_timeout. mem_timeout stays set until rst. mem_timeout does not alter stalls.
- stall_cycles increments each cycle stallF=1 and saturates at all-ones.
- Priority is implicit: memory wait freezes F..M; MDU freezes F..E; hazard freezes F..D; redirect only when D is free.
- Reset mid-operation (MDU active, memory waiting) clears all state in one cycle. No pending op survives.

Decomposition:
- Shared package holds the default constants MDU_CYCLES_DEF=32 and MEM_TIMEOUT_DEF=255, plus the stage index localparams.
- One natural sub-module: mdu_cycle_counter (load/decrement/done/hold). Everything else stays inline.

Test Plan:
- rst=1 for 2 cycles with random inputs, then inputs 0 -> all outputs 0, stall_cycles=0.
- mdu_startE held, MDU_CYCLES=4 -> stallF..stallE=1 and flushM=1 for 4 cycles, then mdu_doneE=1 on cycle 5 with stalls 0; stall_cycles=4.
- hazard_stallD=1 one cycle with branch_takenD=1 -> stallF=stallD=1, flushE=1, flushD=0; next cycle hazard=0 -> flushD=1.
- dmem_reqM=1, ack after 3 cycles -> stallF..stallM=1 and flushW=1 for 3 cycles, flushE=flushM=0; ack cycle -> all 0.
- MDU active (cnt=1) with concurrent 3-cycle mem wait -> counter reaches 0, mdu_doneE held high 2+ cycles, active clears only on ack cycle.
- MEM_TIMEOUT=4, req with no ack for 6 cycles -> mem_timeout rises after 4th wait cycle, stays 1 after ack, clears only on rst.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline_stall_ctrl_pkg;

  // Default mult/div occupancy of E and memory-wait timeout threshold.
  localparam int MDU_CYCLES_DEF  = 32;
  localparam int MEM_TIMEOUT_DEF = 255;

  // Pipeline stage indices, F is the youngest stage.
  localparam int STAGE_F = 0;
  localparam int STAGE_D = 1;
  localparam int STAGE_E = 2;
  localparam int STAGE_M = 3;
  localparam int STAGE_W = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle of stall requests in and per-stage stall/flush controls out.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller drives the slave-side outputs.
interface pipeline_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  // Requests from the pipeline.
  logic              hazard_stallD;
  logic              branch_takenD;
  logic              mdu_startE;
  logic              dmem_reqM;
  logic              dmem_ackM;
  // Per-stage controls and status back to the pipeline.
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic              mdu_busy;
  logic              mdu_doneE;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline side: raises requests, consumes controls.
  modport master (
    output hazard_stallD, branch_takenD, mdu_startE, dmem_reqM, dmem_ackM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    input  mdu_busy, mdu_doneE, mem_timeout, stall_cycles
  );

  // Controller side.
  modport slave (
    input  hazard_stallD, branch_takenD, mdu_startE, dmem_reqM, dmem_ackM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    output mdu_busy, mdu_doneE, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl_mdu_cycle_counter.sv
// Counts the cycles a mult/div occupies E and flags when its result is ready.
// Latency: done_o rises MDU_CYCLES cycles after the start is first seen.
// Backpressure: hold_i keeps done_o asserted until the op can leave E.
module pipeline_stall_ctrl_mdu_cycle_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic hold_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_CYCLES - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign busy_o = active_q;
  assign done_o = active_q & (cnt_q == '0);

  // Load on a fresh op, count down even while memory stalls, and only
  // retire once the op is actually free to leave E.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        cnt_d    = LOAD_VAL;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!hold_i) begin
      active_d = 1'b0;
    end
  end

  // State registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges hazard, mult/div, memory-wait and redirect into per-stage stall/flush.
// Latency: stall/flush are combinational from requests and current state.
// Backpressure: memory wait freezes F..M, MDU F..E, hazard F..D; redirect only when D moves.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES  = MDU_CYCLES_DEF,
  parameter int CNT_W       = 6,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int PERF_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave ctrl
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic                   mem_stall;
  logic                   mdu_stall;
  logic                   mdu_done;
  logic                   mdu_active;
  logic [STAGE_W:STAGE_F] stall_vec;
  logic [STAGE_W:STAGE_D] flush_vec;

  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic [PERF_W-1:0]      stall_cycles_q, stall_cycles_d;

  assign mem_stall = ctrl.dmem_reqM & ~ctrl.dmem_ackM;
  assign mdu_stall = ctrl.mdu_startE & ~mdu_done;

  pipeline_stall_ctrl_mdu_cycle_counter #(
    .MDU_CYCLES (MDU_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .start_i (ctrl.mdu_startE),
    .hold_i  (mem_stall),
    .busy_o  (mdu_active),
    .done_o  (mdu_done)
  );

  // Each stall source freezes its own stage and everything younger; W never stalls.
  always_comb begin
    stall_vec          = '0;
    stall_vec[STAGE_M] = mem_stall;
    stall_vec[STAGE_E] = mem_stall | mdu_stall;
    stall_vec[STAGE_D] = stall_vec[STAGE_E] | ctrl.hazard_stallD;
    stall_vec[STAGE_F] = stall_vec[STAGE_D];
  end

  // A bubble goes in wherever a frozen stage feeds one that moves; a redirect
  // under stall is dropped since D re-resolves the branch next time round.
  always_comb begin
    flush_vec          = '0;
    flush_vec[STAGE_D] = ctrl.branch_takenD & ~stall_vec[STAGE_D];
    for (int s = STAGE_E; s <= STAGE_W; s++) begin
      flush_vec[s] = stall_vec[s-1] & ~stall_vec[s];
    end
  end

  // Track consecutive memory-wait cycles and latch the timeout flag.
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_MAX) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  // Saturating count of cycles the front end was held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_vec[STAGE_F] && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctrl.stallF       = stall_vec[STAGE_F];
  assign ctrl.stallD       = stall_vec[STAGE_D];
  assign ctrl.stallE       = stall_vec[STAGE_E];
  assign ctrl.stallM       = stall_vec[STAGE_M];
  assign ctrl.flushD       = flush_vec[STAGE_D];
  assign ctrl.flushE       = flush_vec[STAGE_E];
  assign ctrl.flushM       = flush_vec[STAGE_M];
  assign ctrl.flushW       = flush_vec[STAGE_W];
  assign ctrl.mdu_busy     = mdu_active;
  assign ctrl.mdu_doneE    = mdu_done;
  assign ctrl.mem_timeout  = mem_timeout_q;
  assign ctrl.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, then random traffic vs a reference model.
// Latency: outputs sampled on the falling edge of each cycle.
// Backpressure: n/a.
module tb_pipeline_stall_ctrl;

  localparam int     MDU_CYC = 4;
  localparam int     TMO     = 4;
  localparam int     PW      = 32;
  localparam longint SC_MAX  = (longint'(1) << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.PERF_W(PW)) bus ();

  pipeline_stall_ctrl #(
    .MDU_CYCLES  (MDU_CYC),
    .CNT_W       (3),
    .MEM_TIMEOUT (TMO),
    .PERF_W      (PW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  // Directed vectors: inputs {hazard, branch, mdu, req, ack}; expected
  // {stallF,stallD,stallE,stallM, flushD,flushE,flushM,flushW, busy,done,timeout}.
  typedef struct {
    logic        r;
    logic [4:0]  in;
    logic [10:0] exp;
    int unsigned sc;
  } vec_t;

  vec_t tab[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: the op in E is tracked by how many cycles it has
  // spent there; memory wait by the length of the current wait run.
  bit     m_in_op;
  int     m_age;
  int     m_wait;
  bit     m_tmo;
  longint m_sc;

  function automatic logic [10:0] model_out(input logic [4:0] in);
    logic hz, br, mdu, req, ack, ms, done, s_m, s_e, s_d;
    {hz, br, mdu, req, ack} = in;
    ms   = req & ~ack;
    done = m_in_op && (m_age >= MDU_CYC);
    s_m  = ms;
    s_e  = ms | (mdu & ~done);
    s_d  = s_e | hz;
    return {s_d, s_d, s_e, s_m, br & ~s_d, s_d & ~s_e, s_e & ~s_m, s_m,
            logic'(m_in_op), done, logic'(m_tmo)};
  endfunction

  task automatic model_edge(input logic r, input logic [4:0] in);
    logic [10:0] o;
    logic        ms, done;
    o    = model_out(in);
    ms   = in[1] & ~in[0];
    done = o[1];
    if (r) begin
      m_in_op = 1'b0;
      m_age   = 0;
      m_wait  = 0;
      m_tmo   = 1'b0;
      m_sc    = 0;
    end else begin
      if (o[10] && m_sc < SC_MAX) m_sc++;
      if (ms) begin
        if (m_wait < TMO) m_wait++;
        if (m_wait >= TMO) m_tmo = 1'b1;
      end else begin
        m_wait = 0;
      end
      if (!m_in_op) begin
        if (in[2]) begin
          m_in_op = 1'b1;
          m_age   = 1;
        end
      end else if (done && !ms) begin
        m_in_op = 1'b0;
      end else begin
        m_age++;
      end
    end
  endtask

  // mode 0: no check, 1: compare with table entry, 2: compare with model.
  task automatic step(input int mode, input logic r, input logic [4:0] in,
                      input logic [10:0] t_exp, input int unsigned t_sc, input string name);
    logic [10:0]   exp, act;
    logic [PW-1:0] exp_sc;
    rst = r;
    {bus.hazard_stallD, bus.branch_takenD, bus.mdu_startE, bus.dmem_reqM, bus.dmem_ackM} = in;
    @(negedge clk);
    if (mode != 0) begin
      exp    = (mode == 1) ? t_exp : model_out(in);
      exp_sc = (mode == 1) ? PW'(t_sc) : m_sc[PW-1:0];
      act    = {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                bus.flushD, bus.flushE, bus.flushM, bus.flushW,
                bus.mdu_busy, bus.mdu_doneE, bus.mem_timeout};
      checks++;
      if (act === exp && bus.stall_cycles === exp_sc) begin
        passed++;
      end else begin
        $display("FAIL %s: got outputs=%b stall_cycles=%0d, required outputs=%b stall_cycles=%0d",
                 name, act, bus.stall_cycles, exp, exp_sc);
      end
    end
    model_edge(r, in);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic r, input logic [4:0] in,
                             input logic [10:0] e, input int unsigned sc);
    vec_t x;
    x.r = r; x.in = in; x.exp = e; x.sc = sc;
    return x;
  endfunction

  initial begin
    // Reset and idle.
    tab.push_back(v(1, 5'b00000, 11'b0000_0000_000, 0));
    // Mult/div held in E for MDU_CYCLES stall cycles, then done.
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_000, 0));
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_100, 1));
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_100, 2));
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_100, 3));
    tab.push_back(v(0, 5'b00100, 11'b0000_0000_110, 4));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_000, 4));
    // Hazard stall defers the redirect by one cycle.
    tab.push_back(v(0, 5'b11000, 11'b1100_0100_000, 4));
    tab.push_back(v(0, 5'b01000, 11'b0000_1000_000, 5));
    // Three-cycle memory wait, then ack.
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 5));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 6));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 7));
    tab.push_back(v(0, 5'b00011, 11'b0000_0000_000, 8));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_000, 8));
    // MDU reaches zero under a memory wait: done held until ack.
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_000, 8));
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_100, 9));
    tab.push_back(v(0, 5'b00100, 11'b1110_0010_100, 10));
    tab.push_back(v(0, 5'b00110, 11'b1111_0001_100, 11));
    tab.push_back(v(0, 5'b00110, 11'b1111_0001_110, 12));
    tab.push_back(v(0, 5'b00110, 11'b1111_0001_110, 13));
    tab.push_back(v(0, 5'b00111, 11'b0000_0000_110, 14));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_000, 14));
    // Six-cycle wait: timeout appears after the fourth and is sticky.
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 14));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 15));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 16));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_000, 17));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_001, 18));
    tab.push_back(v(0, 5'b00010, 11'b1111_0001_001, 19));
    tab.push_back(v(0, 5'b00011, 11'b0000_0000_001, 20));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_001, 20));
    tab.push_back(v(1, 5'b00000, 11'b0000_0000_001, 20));
    tab.push_back(v(1, 5'b00000, 11'b0000_0000_000, 0));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_000, 0));
    // Reset in the middle of an MDU op and a memory wait.
    tab.push_back(v(0, 5'b00110, 11'b1111_0001_000, 0));
    tab.push_back(v(1, 5'b00110, 11'b1111_0001_100, 1));
    tab.push_back(v(0, 5'b00000, 11'b0000_0000_000, 0));

    // Two reset cycles with random inputs, unchecked.
    for (int i = 0; i < 2; i++) begin
      step(0, 1'b1, 5'($urandom), 11'b0, 0, "rst");
    end

    foreach (tab[i]) begin
      step(1, tab[i].r, tab[i].in, tab[i].exp, tab[i].sc, $sformatf("vec%0d", i));
    end

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] in;
      logic       r;
      r     = ($urandom_range(0, 199) == 0);
      in[4] = ($urandom_range(0, 7) == 0);
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 2) != 0);
      in[1] = ($urandom_range(0, 1) == 0);
      in[0] = ($urandom_range(0, 2) == 0);
      step(2, r, in, 11'b0, 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
